// File: rtl/prt_scaler_pkg.sv
// Shared types and constants for the bilinear up-scaling kernel.
// The lerp width helper sizes the blend intermediate: P_BPC data bits plus a 9-bit weight.
package prt_scaler_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WFS,
      WRDY,
      ACT,
      EOL
   } krnl_state_t;

   localparam int P_FRAC_W = 12;
   localparam int P_WGT_W  = 8;

   function automatic int lerp_acc_w(input int bpc);
      return bpc + P_WGT_W + 1;
   endfunction

endpackage

// File: rtl/prt_scaler_krnl_if.sv
// Control, sliding-window and video signals of one kernel instance.
// The master side drives control and window data; the slave side is the kernel.
interface prt_scaler_krnl_if #(
   parameter int P_PPC = 4,
   parameter int P_BPC = 8
);
   logic                   CTL_RUN_IN;
   logic                   CTL_FS_IN;
   logic [15:0]            CTL_HINC_IN;
   logic [15:0]            CTL_VINC_IN;
   logic [13:0]            CTL_W_IN;
   logic [13:0]            CTL_H_IN;
   logic                   SLW_RDY_IN;
   logic [5*P_BPC-1:0]     SLW_DAT0_IN;
   logic [5*P_BPC-1:0]     SLW_DAT1_IN;
   logic [1:0]             SLW_STEP_OUT;
   logic                   SLW_LRST_OUT;
   logic                   SLW_LNXT_OUT;
   logic                   VID_DE_OUT;
   logic                   VID_EOL_OUT;
   logic [P_PPC*P_BPC-1:0] VID_DAT_OUT;

   modport master (
      output CTL_RUN_IN, CTL_FS_IN, CTL_HINC_IN, CTL_VINC_IN, CTL_W_IN, CTL_H_IN,
      output SLW_RDY_IN, SLW_DAT0_IN, SLW_DAT1_IN,
      input  SLW_STEP_OUT, SLW_LRST_OUT, SLW_LNXT_OUT,
      input  VID_DE_OUT, VID_EOL_OUT, VID_DAT_OUT
   );

   modport slave (
      input  CTL_RUN_IN, CTL_FS_IN, CTL_HINC_IN, CTL_VINC_IN, CTL_W_IN, CTL_H_IN,
      input  SLW_RDY_IN, SLW_DAT0_IN, SLW_DAT1_IN,
      output SLW_STEP_OUT, SLW_LRST_OUT, SLW_LNXT_OUT,
      output VID_DE_OUT, VID_EOL_OUT, VID_DAT_OUT
   );
endinterface

// File: rtl/prt_scaler_krnl_lerp.sv
// One registered two-tap blend: y = (a*(256-w) + b*w + 128) >> 8.
// Cleared synchronously so the video data reads zero while the kernel is idle.
module prt_scaler_krnl_lerp
   import prt_scaler_pkg::*;
#(
   parameter int P_BPC = 8
) (
   input  logic               i_clk,
   input  logic               i_clr,
   input  logic [P_BPC-1:0]   i_a,
   input  logic [P_BPC-1:0]   i_b,
   input  logic [P_WGT_W-1:0] i_w,
   output logic [P_BPC-1:0]   o_y
);
   localparam int L_ACC_W = lerp_acc_w(P_BPC);

   logic [P_WGT_W:0]   w_wa;
   logic [L_ACC_W-1:0] w_acc;

   always_comb begin
      w_wa  = (P_WGT_W+1)'(1 << P_WGT_W) - {1'b0, i_w};
      w_acc = L_ACC_W'(i_a) * L_ACC_W'(w_wa) + L_ACC_W'(i_b) * L_ACC_W'(i_w)
            + L_ACC_W'(1 << (P_WGT_W - 1));
   end

   always_ff @(posedge i_clk) begin
      if (i_clr) o_y <= '0;
      else       o_y <= w_acc[P_WGT_W +: P_BPC];
   end

endmodule

// File: rtl/prt_scaler_krnl.sv
// Bilinear up-scaling kernel: line FSM, phase accumulators, phase delay line matching
// the sliding-window latency, 5:1 window muxes and a two-stage lerp pipeline.
//
// state | meaning
// IDLE  | run low, everything cleared
// WFS   | waiting for frame start
// WRDY  | waiting for the window to become valid
// ACT   | issuing CTL_W_IN clocks of steps and phases
// EOL   | draining the pipeline, then line pulse or end of frame
module prt_scaler_krnl
   import prt_scaler_pkg::*;
#(
   parameter int P_PPC     = 4,
   parameter int P_BPC     = 8,
   parameter int P_SLW_LAT = 7
) (
   input  logic             CLK_IN,
   input  logic             RST_IN,
   prt_scaler_krnl_if.slave io_bus
);
   localparam int L_PH_W = P_FRAC_W + 2;
   localparam int L_IX_W = 2 + P_WGT_W;

   krnl_state_t r_state, w_state_nxt;

   logic [L_PH_W-1:0]  r_hinc;
   logic [12:0]        r_vinc;
   logic [13:0]        r_w, r_h, r_line, r_cnt;
   logic [11:0]        r_hacc, r_vacc;
   logic [P_WGT_W-1:0] r_wv;

   logic [P_SLW_LAT-1:0]    r_dl_vld, r_dl_eol;
   logic [P_PPC*L_IX_W-1:0] r_dl_ph [P_SLW_LAT];
   logic                    r_v1, r_e1, r_v2, r_e2;

   logic               w_clr, w_fs, w_act, w_drained, w_last_line, w_line_end;
   logic [1:0]         w_step;
   logic               w_lrst, w_lnxt;
   logic [L_PH_W-1:0]  w_hsum;
   logic [12:0]        w_vsum;
   logic [L_PH_W-1:0]  w_ph [P_PPC];
   logic [P_PPC*L_IX_W-1:0] w_ph_pk;
   logic               w_unused;

   assign w_clr       = RST_IN | ~io_bus.CTL_RUN_IN;
   assign w_fs        = io_bus.CTL_FS_IN;
   assign w_hsum      = {2'b00, r_hacc} + {r_hinc[11:0], 2'b00};
   assign w_vsum      = {1'b0, r_vacc} + r_vinc;
   assign w_drained   = ~|r_dl_vld & ~r_v1 & ~r_v2;
   assign w_last_line = (r_line == r_h - 14'd1);
   assign w_line_end  = (r_cnt == 14'd0);

   always_comb begin
      w_ph_pk  = '0;
      w_unused = ^{io_bus.CTL_HINC_IN[15:14], io_bus.CTL_VINC_IN[15:13]};
      for (int k = 0; k < P_PPC; k++) begin
         w_ph[k] = {2'b00, r_hacc} + L_PH_W'(k) * r_hinc;
         w_ph_pk[k*L_IX_W +: L_IX_W] = w_ph[k][L_PH_W-1 -: L_IX_W];
         w_unused = w_unused ^ (^w_ph[k][L_PH_W-L_IX_W-1:0]);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_step      = 2'd0;
      w_lrst      = 1'b0;
      w_lnxt      = 1'b0;
      w_act       = 1'b0;
      case (r_state)
         IDLE: w_state_nxt = WFS;
         WFS:  w_state_nxt = WFS;
         WRDY: if (io_bus.SLW_RDY_IN) w_state_nxt = ACT;
         ACT: begin
            w_act  = 1'b1;
            w_step = w_hsum[13:12];
            if (w_line_end) w_state_nxt = EOL;
         end
         EOL: begin
            if (w_drained) begin
               if (w_last_line) begin
                  w_state_nxt = WFS;
               end else begin
                  w_state_nxt = WRDY;
                  w_lnxt      = w_vsum[12];
                  w_lrst      = ~w_vsum[12];
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      // frame start overrides whatever the current state wanted to do this clock
      if (w_fs) begin
         w_state_nxt = WRDY;
         w_step      = 2'd0;
         w_lrst      = 1'b0;
         w_lnxt      = 1'b0;
         w_act       = 1'b0;
      end
      if (w_clr) begin
         w_state_nxt = IDLE;
         w_step      = 2'd0;
         w_lrst      = 1'b0;
         w_lnxt      = 1'b0;
         w_act       = 1'b0;
      end
   end

   always_ff @(posedge CLK_IN) begin
      if (w_clr) begin
         r_state <= IDLE;
         r_hinc  <= '0;
         r_vinc  <= '0;
         r_w     <= '0;
         r_h     <= '0;
         r_line  <= '0;
         r_cnt   <= '0;
         r_hacc  <= '0;
         r_vacc  <= '0;
         r_wv    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_fs) begin
            r_hinc <= io_bus.CTL_HINC_IN[L_PH_W-1:0];
            r_vinc <= io_bus.CTL_VINC_IN[12:0];
            r_w    <= io_bus.CTL_W_IN;
            r_h    <= io_bus.CTL_H_IN;
            r_line <= '0;
            r_hacc <= '0;
            r_vacc <= '0;
         end else if (r_state == WRDY && io_bus.SLW_RDY_IN) begin
            r_hacc <= '0;
            r_cnt  <= r_w - 14'd1;
            r_wv   <= r_vacc[11:4];
         end else if (w_act) begin
            r_hacc <= w_hsum[11:0];
            if (!w_line_end) r_cnt <= r_cnt - 14'd1;
         end else if (w_lrst || w_lnxt) begin
            r_vacc <= w_vsum[11:0];
            r_line <= r_line + 14'd1;
         end
      end
   end

   always_ff @(posedge CLK_IN) begin
      if (w_clr || w_fs) begin
         r_dl_vld <= '0;
         r_dl_eol <= '0;
      end else begin
         r_dl_vld <= {r_dl_vld[P_SLW_LAT-2:0], w_act};
         r_dl_eol <= {r_dl_eol[P_SLW_LAT-2:0], w_act & w_line_end};
      end
      r_dl_ph[0] <= w_ph_pk;
      for (int i = 1; i < P_SLW_LAT; i++) r_dl_ph[i] <= r_dl_ph[i-1];
   end

   // valid and end-of-line ride alongside the two lerp stages; window ready gates DE
   always_ff @(posedge CLK_IN) begin
      if (w_clr) begin
         r_v1 <= 1'b0;
         r_e1 <= 1'b0;
         r_v2 <= 1'b0;
         r_e2 <= 1'b0;
      end else begin
         r_v1 <= r_dl_vld[P_SLW_LAT-1] & io_bus.SLW_RDY_IN;
         r_e1 <= r_dl_eol[P_SLW_LAT-1];
         r_v2 <= r_v1;
         r_e2 <= r_e1;
      end
   end

   logic [P_BPC-1:0] w_d0 [5];
   logic [P_BPC-1:0] w_d1 [5];
   logic [P_BPC-1:0] w_h0 [P_PPC];
   logic [P_BPC-1:0] w_h1 [P_PPC];
   logic [P_BPC-1:0] w_y  [P_PPC];
   logic [P_PPC*P_BPC-1:0] w_dat;

   for (genvar j = 0; j < 5; j++) begin : g_win
      assign w_d0[j] = io_bus.SLW_DAT0_IN[j*P_BPC +: P_BPC];
      assign w_d1[j] = io_bus.SLW_DAT1_IN[j*P_BPC +: P_BPC];
   end

   for (genvar k = 0; k < P_PPC; k++) begin : g_pix
      logic [1:0]         w_idx;
      logic [P_WGT_W-1:0] w_wh;
      logic [2:0]         w_ia, w_ib;

      assign {w_idx, w_wh} = r_dl_ph[P_SLW_LAT-1][k*L_IX_W +: L_IX_W];
      assign w_ia = {1'b0, w_idx};
      assign w_ib = {1'b0, w_idx} + 3'd1;

      prt_scaler_krnl_lerp #(.P_BPC(P_BPC)) u_h0 (
         .i_clk(CLK_IN), .i_clr(w_clr), .i_a(w_d0[w_ia]), .i_b(w_d0[w_ib]),
         .i_w(w_wh), .o_y(w_h0[k])
      );
      prt_scaler_krnl_lerp #(.P_BPC(P_BPC)) u_h1 (
         .i_clk(CLK_IN), .i_clr(w_clr), .i_a(w_d1[w_ia]), .i_b(w_d1[w_ib]),
         .i_w(w_wh), .o_y(w_h1[k])
      );
      prt_scaler_krnl_lerp #(.P_BPC(P_BPC)) u_v (
         .i_clk(CLK_IN), .i_clr(w_clr), .i_a(w_h0[k]), .i_b(w_h1[k]),
         .i_w(r_wv), .o_y(w_y[k])
      );
   end

   always_comb begin
      w_dat = '0;
      for (int k = 0; k < P_PPC; k++) w_dat[k*P_BPC +: P_BPC] = w_y[k];
   end

   assign io_bus.SLW_STEP_OUT = w_step;
   assign io_bus.SLW_LRST_OUT = w_lrst;
   assign io_bus.SLW_LNXT_OUT = w_lnxt;
   assign io_bus.VID_DE_OUT   = r_v2;
   assign io_bus.VID_EOL_OUT  = r_v2 & r_e2;
   assign io_bus.VID_DAT_OUT  = w_dat;

endmodule

// File: tb/tb_prt_scaler_krnl.sv
// Directed bench for prt_scaler_krnl: hand-computed steps, line pulses and pixel values.
module tb_prt_scaler_krnl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   prt_scaler_krnl_if #(.P_PPC(4), .P_BPC(8)) bus ();

   prt_scaler_krnl #(.P_PPC(4), .P_BPC(8), .P_SLW_LAT(7)) dut (
      .CLK_IN(clk), .RST_IN(rst), .io_bus(bus.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   int          steps_q[$];
   int          pulse_q[$];
   logic [31:0] dat_q[$];
   logic        eol_q[$];
   int          first_step, first_de;

   localparam logic [39:0] RAMP = {8'd50, 8'd40, 8'd30, 8'd20, 8'd10};

   task automatic set_win(input logic [39:0] d0, input logic [39:0] d1);
      bus.SLW_DAT0_IN = d0;
      bus.SLW_DAT1_IN = d1;
   endtask

   task automatic start_frame(input logic [15:0] hinc, input logic [15:0] vinc,
                              input logic [13:0] w, input logic [13:0] h);
      assert (hinc >= 16'h0001 && hinc <= 16'h0C00) else $error("illegal HINC %h", hinc);
      bus.CTL_HINC_IN = hinc;
      bus.CTL_VINC_IN = vinc;
      bus.CTL_W_IN    = w;
      bus.CTL_H_IN    = h;
      bus.CTL_FS_IN   = 1'b1;
      @(negedge clk);
      bus.CTL_FS_IN   = 1'b0;
   endtask

   task automatic capture(input int n);
      steps_q.delete(); pulse_q.delete(); dat_q.delete(); eol_q.delete();
      first_step = -1; first_de = -1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (bus.SLW_STEP_OUT != 2'd0) begin
            steps_q.push_back(int'(bus.SLW_STEP_OUT));
            if (first_step < 0) first_step = i;
         end
         if (bus.SLW_LRST_OUT) pulse_q.push_back(1);
         if (bus.SLW_LNXT_OUT) pulse_q.push_back(2);
         if (bus.VID_DE_OUT) begin
            dat_q.push_back(bus.VID_DAT_OUT);
            eol_q.push_back(bus.VID_EOL_OUT);
            if (first_de < 0) first_de = i;
         end
      end
   endtask

   task automatic test_reset();
      bus.CTL_RUN_IN = 1'b0; bus.CTL_FS_IN = 1'b0; bus.SLW_RDY_IN = 1'b0;
      bus.CTL_HINC_IN = '0; bus.CTL_VINC_IN = '0; bus.CTL_W_IN = '0; bus.CTL_H_IN = '0;
      set_win(RAMP, RAMP);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({bus.SLW_STEP_OUT, bus.SLW_LRST_OUT, bus.SLW_LNXT_OUT, bus.VID_DE_OUT, bus.VID_EOL_OUT} !== 6'd0) begin
         n_fail++; $display("FAIL reset_ctl got %b exp 0", {bus.SLW_STEP_OUT, bus.SLW_LRST_OUT, bus.SLW_LNXT_OUT, bus.VID_DE_OUT, bus.VID_EOL_OUT});
      end
      n_tests++;
      if (bus.VID_DAT_OUT !== 32'h0) begin
         n_fail++; $display("FAIL reset_dat got %h exp 0", bus.VID_DAT_OUT);
      end
      rst = 1'b0;
      bus.CTL_RUN_IN = 1'b1;
      bus.SLW_RDY_IN = 1'b1;
      capture(10);
      n_tests++;
      if (steps_q.size() != 0) begin
         n_fail++; $display("FAIL reset_wait_fs steps got %0d exp 0", steps_q.size());
      end
   endtask

   task automatic test_basic();
      set_win(RAMP, RAMP);
      bus.SLW_RDY_IN = 1'b1;
      start_frame(16'h0800, 16'h1000, 14'd2, 14'd2);
      capture(60);
      n_tests++;
      if (steps_q.size() != 4 || steps_q[0] != 2 || steps_q[1] != 2) begin
         n_fail++; $display("FAIL basic_steps got n=%0d s0=%0d exp n=4 s0=2 s1=2", steps_q.size(), steps_q.size() > 0 ? steps_q[0] : -1);
      end
      n_tests++;
      if (first_de - first_step != 9) begin
         n_fail++; $display("FAIL basic_latency got %0d exp 9", first_de - first_step);
      end
      n_tests++;
      if (dat_q.size() < 1 || dat_q[0] !== 32'h19140F0A) begin
         n_fail++; $display("FAIL basic_first_dat got %h exp 19140f0a", dat_q.size() > 0 ? dat_q[0] : 32'hx);
      end
      n_tests++;
      if (dat_q.size() != 4) begin
         n_fail++; $display("FAIL basic_de_cnt got %0d exp 4", dat_q.size());
      end
      n_tests++;
      if (eol_q.size() != 4 || eol_q[0] !== 1'b0 || eol_q[1] !== 1'b1 || eol_q[3] !== 1'b1) begin
         n_fail++; $display("FAIL basic_eol got n=%0d exp pattern 0101", eol_q.size());
      end
      n_tests++;
      if (pulse_q.size() != 1 || pulse_q[0] != 2) begin
         n_fail++; $display("FAIL basic_lnxt got n=%0d exp one LNXT", pulse_q.size());
      end
   endtask

   task automatic test_hinc_max();
      set_win(RAMP, RAMP);
      bus.SLW_RDY_IN = 1'b1;
      start_frame(16'h0C00, 16'h1000, 14'd2, 14'd1);
      capture(30);
      n_tests++;
      if (steps_q.size() != 2 || steps_q[0] != 3 || steps_q[1] != 3) begin
         n_fail++; $display("FAIL hmax_steps got n=%0d exp two steps of 3", steps_q.size());
      end
      n_tests++;
      if (dat_q.size() != 2 || dat_q[0] !== 32'h2119120A || dat_q[1] !== 32'h2119120A) begin
         n_fail++; $display("FAIL hmax_dat got %h exp 2119120a twice", dat_q.size() > 0 ? dat_q[0] : 32'hx);
      end
      n_tests++;
      if (pulse_q.size() != 0) begin
         n_fail++; $display("FAIL hmax_pulse got %0d exp 0", pulse_q.size());
      end
   endtask

   task automatic test_vertical();
      set_win(40'h0, {5{8'hFF}});
      bus.SLW_RDY_IN = 1'b1;
      start_frame(16'h0400, 16'h0800, 14'd1, 14'd4);
      capture(80);
      n_tests++;
      if (pulse_q.size() != 3 || pulse_q[0] != 1 || pulse_q[1] != 2 || pulse_q[2] != 1) begin
         n_fail++; $display("FAIL vert_pulses got n=%0d exp LRST LNXT LRST", pulse_q.size());
      end
      n_tests++;
      if (dat_q.size() != 4 || dat_q[0] !== 32'h0 || dat_q[1] !== 32'h80808080
          || dat_q[2] !== 32'h0 || dat_q[3] !== 32'h80808080) begin
         n_fail++; $display("FAIL vert_dat got n=%0d d1=%h exp 0,80808080,0,80808080", dat_q.size(), dat_q.size() > 1 ? dat_q[1] : 32'hx);
      end
   endtask

   task automatic test_saturate();
      set_win({5{8'hFF}}, {5{8'hFF}});
      bus.SLW_RDY_IN = 1'b1;
      start_frame(16'h0555, 16'h0800, 14'd1, 14'd2);
      capture(40);
      n_tests++;
      if (dat_q.size() != 2 || dat_q[0] !== 32'hFFFFFFFF || dat_q[1] !== 32'hFFFFFFFF) begin
         n_fail++; $display("FAIL sat_dat got %h exp ffffffff", dat_q.size() > 0 ? dat_q[0] : 32'hx);
      end
   endtask

   task automatic test_fs_abort();
      set_win(RAMP, RAMP);
      bus.SLW_RDY_IN = 1'b1;
      start_frame(16'h0300, 16'h1000, 14'd8, 14'd1);
      repeat (3) @(negedge clk);
      bus.SLW_RDY_IN  = 1'b0;
      bus.CTL_HINC_IN = 16'h0400;
      bus.CTL_FS_IN   = 1'b1;
      @(negedge clk);
      bus.CTL_FS_IN   = 1'b0;
      n_tests++;
      if (bus.SLW_STEP_OUT !== 2'd0) begin
         n_fail++; $display("FAIL abort_step_stop got %0d exp 0", bus.SLW_STEP_OUT);
      end
      capture(15);
      n_tests++;
      if (steps_q.size() != 0 || dat_q.size() != 0) begin
         n_fail++; $display("FAIL abort_quiet got steps=%0d de=%0d exp 0 0", steps_q.size(), dat_q.size());
      end
      bus.SLW_RDY_IN = 1'b1;
      capture(40);
      n_tests++;
      if (first_step != 0 || steps_q.size() != 8) begin
         n_fail++; $display("FAIL abort_restart got first=%0d n=%0d exp 0 8", first_step, steps_q.size());
      end
      n_tests++;
      if (dat_q.size() < 1 || dat_q[0] !== 32'h120F0D0A || first_de - first_step != 9) begin
         n_fail++; $display("FAIL abort_new_dat got %h lat=%0d exp 120f0d0a lat=9", dat_q.size() > 0 ? dat_q[0] : 32'hx, first_de - first_step);
      end
   endtask

   task automatic test_run_drop();
      set_win(RAMP, RAMP);
      bus.SLW_RDY_IN = 1'b1;
      start_frame(16'h0400, 16'h1000, 14'd8, 14'd1);
      repeat (10) @(negedge clk);
      n_tests++;
      if (bus.VID_DE_OUT !== 1'b1) begin
         n_fail++; $display("FAIL drop_pre_de got %b exp 1", bus.VID_DE_OUT);
      end
      bus.CTL_RUN_IN = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({bus.SLW_STEP_OUT, bus.SLW_LRST_OUT, bus.SLW_LNXT_OUT, bus.VID_DE_OUT, bus.VID_EOL_OUT} !== 6'd0
          || bus.VID_DAT_OUT !== 32'h0) begin
         n_fail++; $display("FAIL drop_outputs got de=%b dat=%h step=%0d exp all 0", bus.VID_DE_OUT, bus.VID_DAT_OUT, bus.SLW_STEP_OUT);
      end
      bus.CTL_RUN_IN = 1'b1;
      capture(15);
      n_tests++;
      if (steps_q.size() != 0 || dat_q.size() != 0) begin
         n_fail++; $display("FAIL drop_no_restart got steps=%0d de=%0d exp 0 0", steps_q.size(), dat_q.size());
      end
      start_frame(16'h0400, 16'h1000, 14'd1, 14'd1);
      capture(30);
      n_tests++;
      if (steps_q.size() != 1 || steps_q[0] != 1 || dat_q.size() != 1) begin
         n_fail++; $display("FAIL drop_restart got steps=%0d de=%0d exp 1 1", steps_q.size(), dat_q.size());
      end
   endtask

   task automatic test_rst_mid();
      set_win(RAMP, RAMP);
      bus.SLW_RDY_IN = 1'b1;
      start_frame(16'h0400, 16'h1000, 14'd8, 14'd1);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_tests++;
      if (bus.VID_DE_OUT !== 1'b0 || bus.VID_DAT_OUT !== 32'h0 || bus.SLW_STEP_OUT !== 2'd0) begin
         n_fail++; $display("FAIL rst_outputs got de=%b dat=%h step=%0d exp all 0", bus.VID_DE_OUT, bus.VID_DAT_OUT, bus.SLW_STEP_OUT);
      end
      capture(15);
      n_tests++;
      if (steps_q.size() != 0 || dat_q.size() != 0) begin
         n_fail++; $display("FAIL rst_no_restart got steps=%0d de=%0d exp 0 0", steps_q.size(), dat_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hinc_max();
      test_vertical();
      test_saturate();
      test_fs_abort();
      test_run_drop();
      test_rst_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
